// File: rtl/wb_timer_if.sv
// Wishbone-style classic bus bundle for the wb_timer register window.
// The master drives CYC/STB/WE/ADR/DAT_O; the timer returns DAT_I/ACK.
interface wb_timer_if;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK;

    modport master (output CYC, STB, WE, ADR, DAT_O, input DAT_I, ACK);
    modport slave  (input CYC, STB, WE, ADR, DAT_O, output DAT_I, ACK);
endinterface

// File: rtl/wb_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare and a level irq.
// Optional macro TIMER_SNAPSHOT_EN: a read of MTIME_LO latches mtime[63:32] for a later MTIME_HI read.
module wb_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
    parameter int          PRESCALE_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    wb_timer_if.slave  bus,
    output logic       irq
);

    typedef enum logic {IDLE, RESP} state_t;

    typedef enum logic [2:0] {
        R_MTIME_LO = 3'd0,
        R_MTIME_HI = 3'd1,
        R_CMP_LO   = 3'd2,
        R_CMP_HI   = 3'd3,
        R_CTRL     = 3'd4,
        R_PRESCALE = 3'd5,
        R_RSVD0    = 3'd6,
        R_RSVD1    = 3'd7
    } reg_idx_t;

    state_t                  state_q, state_d;
    logic [31:0]             dat_q, dat_d;
    logic [63:0]             mtime_q, mtime_d;
    logic [63:0]             cmp_q, cmp_d;
    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic                    en_q, en_d;
    logic                    ie_q, ie_d;
    logic                    irq_q, irq_d;
`ifdef TIMER_SNAPSHOT_EN
    logic [31:0]             shadow_q, shadow_d;
`endif

    reg_idx_t    idx;
    logic        sel;
    logic        req;
    logic        tick;
    logic [31:0] rdata;
    logic        unused_adr_lo;

    assign idx           = reg_idx_t'(bus.ADR[4:2]);
    assign sel           = (bus.ADR[31:5] == BASE_ADDR[31:5]);
    assign req           = bus.CYC & bus.STB & sel;
    assign tick          = en_q && (pre_q == prescale_q);
    assign unused_adr_lo = ^bus.ADR[1:0];

    // Read mux sees pre-write state, so a read returns the value before this edge.
    always_comb begin
        rdata = '0;
        case (idx)
            R_MTIME_LO: rdata = mtime_q[31:0];
`ifdef TIMER_SNAPSHOT_EN
            R_MTIME_HI: rdata = shadow_q;
`else
            R_MTIME_HI: rdata = mtime_q[63:32];
`endif
            R_CMP_LO:   rdata = cmp_q[31:0];
            R_CMP_HI:   rdata = cmp_q[63:32];
            R_CTRL:     rdata = {30'd0, ie_q, en_q};
            R_PRESCALE: rdata = 32'(prescale_q);
            R_RSVD0,
            R_RSVD1:    rdata = '0;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        dat_d      = dat_q;
        mtime_d    = mtime_q;
        cmp_d      = cmp_q;
        pre_d      = pre_q;
        prescale_d = prescale_q;
        en_d       = en_q;
        ie_d       = ie_q;
        irq_d      = ie_q & (mtime_q >= cmp_q);
`ifdef TIMER_SNAPSHOT_EN
        shadow_d   = shadow_q;
`endif

        if (en_q) begin
            if (tick) begin
                pre_d   = '0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                pre_d   = pre_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RESP;
                    dat_d   = rdata;
                    if (bus.WE) begin
                        // A write to either mtime half replaces that tick's increment.
                        case (idx)
                            R_MTIME_LO: mtime_d = {mtime_q[63:32], bus.DAT_O};
                            R_MTIME_HI: mtime_d = {bus.DAT_O, mtime_q[31:0]};
                            R_CMP_LO:   cmp_d[31:0]  = bus.DAT_O;
                            R_CMP_HI:   cmp_d[63:32] = bus.DAT_O;
                            R_CTRL: begin
                                en_d = bus.DAT_O[0];
                                ie_d = bus.DAT_O[1];
                            end
                            R_PRESCALE: begin
                                prescale_d = bus.DAT_O[PRESCALE_W-1:0];
                                pre_d      = '0;
                            end
                            R_RSVD0,
                            R_RSVD1: ;
                        endcase
`ifdef TIMER_SNAPSHOT_EN
                    end else if (idx == R_MTIME_LO) begin
                        shadow_d = mtime_q[63:32];
`endif
                    end
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dat_q      <= '0;
            mtime_q    <= '0;
            cmp_q      <= '1;
            pre_q      <= '0;
            prescale_q <= '0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            irq_q      <= 1'b0;
`ifdef TIMER_SNAPSHOT_EN
            shadow_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dat_q      <= dat_d;
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            pre_q      <= pre_d;
            prescale_q <= prescale_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            irq_q      <= irq_d;
`ifdef TIMER_SNAPSHOT_EN
            shadow_q   <= shadow_d;
`endif
        end
    end

    assign bus.ACK   = (state_q == RESP);
    assign bus.DAT_I = dat_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios plus randomized timer runs
// compared against a closed-form mtime model (ticks = enabled edges / (PRESCALE+1)).
module tb_wb_timer;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          NEVER = 32'h7FFF_FFFF;
    localparam logic [4:0]  O_LO = 5'h00, O_HI = 5'h04, O_CLO = 5'h08, O_CHI = 5'h0C,
                            O_CTRL = 5'h10, O_PRE = 5'h14, O_R18 = 5'h18, O_R1C = 5'h1C;

    logic clk;
    logic rst;
    logic irq;
    int   cyc;
    int   vectors;
    int   miscompares;

    // Behavioural model: mtime after edge x = start + (x - en_edge) / (p + 1)
    logic [63:0] m_start;
    logic [63:0] m_cmp;
    int          m_en_edge;
    int          m_p;
    logic        m_ie;
    logic [31:0] m_snap;

    wb_timer_if bus ();

    wb_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mt_at(input int x);
        if (x <= m_en_edge) return m_start;
        return m_start + 64'((x - m_en_edge) / (m_p + 1));
    endfunction

    function automatic logic [31:0] exp_hi(input int commit);
`ifdef TIMER_SNAPSHOT_EN
        return m_snap;
`else
        logic [63:0] v;
        v = mt_at(commit - 1);
        return v[63:32];
`endif
    endfunction

    function automatic logic exp_irq(input int x);
        return m_ie && (mt_at(x - 1) >= m_cmp);
    endfunction

    // Called at a negedge; returns at a negedge one cycle after the ACK, FSM back in IDLE.
    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                            output logic [31:0] rd, output int commit, output logic irq_ack);
        int   waited;
        logic got;
        logic [63:0] v;
        bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = we; bus.ADR = adr; bus.DAT_O = wd;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 4) begin
            @(negedge clk);
            waited++;
            if (bus.ACK === 1'b1) got = 1'b1;
        end
        rd = bus.DAT_I;
        commit = cyc;
        irq_ack = irq;
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
        vectors++;
        if (!got || waited != 1) begin
            miscompares++;
            $display("FAIL ack_latency adr=%h: ack=%0b after %0d cycles, required ack after 1 cycle",
                     adr, got, waited);
        end
        if (!we && adr[4:2] == 3'd0) begin
            v = mt_at(commit - 1);
            m_snap = v[63:32];
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d, output int commit);
        logic [31:0] rd;
        logic        ia;
        bus_xfer(1'b1, BASE + 32'(off), d, rd, commit, ia);
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] d, output int commit);
        logic ia;
        bus_xfer(1'b0, BASE + 32'(off), 32'd0, d, commit, ia);
    endtask

    task automatic do_reset();
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.ADR = '0; bus.DAT_O = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_start = '0; m_cmp = '1; m_en_edge = NEVER; m_p = 0; m_ie = 1'b0; m_snap = '0;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] d;
        logic [31:0] exp_tab [8];
        int c;
        exp_tab = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4), d, c);
            vectors++;
            if (d !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL %s reg@%02h: got %h, required %h", tag, i * 4, d, exp_tab[i]);
            end
        end
    endtask

    task automatic setup_timer(input int p, input logic [63:0] start, input logic [63:0] cmp,
                               input logic ie);
        int c;
        wr(O_PRE, 32'(p), c);
        wr(O_LO,  start[31:0], c);
        wr(O_HI,  start[63:32], c);
        wr(O_CLO, cmp[31:0], c);
        wr(O_CHI, cmp[63:32], c);
        m_start = start; m_p = p; m_cmp = cmp; m_ie = ie;
        wr(O_CTRL, {30'd0, ie, 1'b1}, c);
        m_en_edge = c;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int c;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.ACK !== 1'b0 || irq !== 1'b0 || bus.DAT_I !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b irq=%b dat=%h, required 0 0 00000000",
                     bus.ACK, irq, bus.DAT_I);
        end
        do_reset();
        rd(O_CHI, d, c);
        vectors++;
        if (d !== 32'hFFFF_FFFF || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cmp_hi: dat=%h irq=%b, required ffffffff 0", d, irq);
        end
        check_reset_regs("reset_regs");
    endtask

    task automatic test_regs();
        logic [31:0] w [4];
        logic [31:0] d;
        int c;
        do_reset();
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        wr(O_CLO, w[0], c);
        wr(O_CHI, w[1], c);
        wr(O_PRE, w[2], c);
        wr(O_CTRL, w[3] & 32'hFFFF_FFFE, c);
        wr(O_R18, 32'hDEAD_BEEF, c);
        rd(O_CLO, d, c);
        vectors++;
        if (d !== w[0]) begin miscompares++; $display("FAIL cmp_lo_rw: got %h, required %h", d, w[0]); end
        rd(O_CHI, d, c);
        vectors++;
        if (d !== w[1]) begin miscompares++; $display("FAIL cmp_hi_rw: got %h, required %h", d, w[1]); end
        rd(O_PRE, d, c);
        vectors++;
        if (d !== (w[2] & 32'h0000_FFFF)) begin
            miscompares++; $display("FAIL prescale_rw: got %h, required %h", d, w[2] & 32'h0000_FFFF);
        end
        rd(O_CTRL, d, c);
        vectors++;
        if (d !== (w[3] & 32'h0000_0002)) begin
            miscompares++; $display("FAIL ctrl_rw: got %h, required %h", d, w[3] & 32'h0000_0002);
        end
        rd(O_R18, d, c);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL rsvd18: got %h, required 0", d); end
        rd(O_R1C, d, c);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL rsvd1c: got %h, required 0", d); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic [63:0] e;
        int c;
        do_reset();
        setup_timer(3, 64'd0, '1, 1'b0);
        repeat (40) @(negedge clk);
        rd(O_LO, d, c);
        e = mt_at(c - 1);
        vectors++;
        if (d !== e[31:0]) begin
            miscompares++; $display("FAIL prescale3_lo: got %0d, required %0d", d, e[31:0]);
        end
    endtask

    task automatic test_carry();
        logic [31:0] d;
        logic [63:0] e;
        int c;
        do_reset();
        setup_timer(0, 64'h0000_0000_FFFF_FFFE, '1, 1'b0);
        rd(O_LO, d, c);
        e = mt_at(c - 1);
        vectors++;
        if (d !== e[31:0]) begin miscompares++; $display("FAIL carry_lo_pre: got %h, required %h", d, e[31:0]); end
        rd(O_HI, d, c);
        vectors++;
        if (d !== exp_hi(c)) begin miscompares++; $display("FAIL carry_hi: got %h, required %h", d, exp_hi(c)); end
        rd(O_LO, d, c);
        e = mt_at(c - 1);
        vectors++;
        if (d !== e[31:0]) begin miscompares++; $display("FAIL carry_lo_post: got %h, required %h", d, e[31:0]); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        ia;
        int          c;
        int          rises;
        do_reset();
        setup_timer(0, 64'd0, 64'd100, 1'b1);
        rises = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (irq === 1'b1 && exp_irq(cyc)) rises = 1;
            vectors++;
            if (irq !== exp_irq(cyc)) begin
                miscompares++;
                $display("FAIL irq_track cyc=%0d: got %b, required %b", cyc, irq, exp_irq(cyc));
            end
        end
        vectors++;
        if (rises == 0) begin miscompares++; $display("FAIL irq_rise: got 0, required irq to rise"); end
        bus_xfer(1'b1, BASE + 32'(O_CLO), 32'd1000, d, c, ia);
        vectors++;
        if (ia !== 1'b1) begin miscompares++; $display("FAIL irq_at_commit: got %b, required 1", ia); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_drop: got %b, required 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int c;
        int acks;
        do_reset();
        bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0; bus.ADR = BASE + 32'h8;
        acks = 0;
        repeat (6) begin @(negedge clk); if (bus.ACK === 1'b1) acks++; end
        bus.CYC = 1'b0; bus.STB = 1'b0;
        @(negedge clk);
        vectors++;
        if (acks != 3) begin miscompares++; $display("FAIL held_acks: got %0d, required 3", acks); end
        bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1; bus.ADR = BASE + 32'h20; bus.DAT_O = 32'h55;
        acks = 0;
        repeat (10) begin @(negedge clk); if (bus.ACK === 1'b1) acks++; end
        bus.WE = 1'b0; bus.ADR = BASE - 32'h4;
        repeat (6) begin @(negedge clk); if (bus.ACK === 1'b1) acks++; end
        bus.CYC = 1'b0; bus.STB = 1'b0;
        @(negedge clk);
        vectors++;
        if (acks != 0) begin miscompares++; $display("FAIL unselected_acks: got %0d, required 0", acks); end
        rd(O_LO, d, c);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL unselected_write: mtime_lo %h, required 0", d); end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        wr(O_CLO, 32'd5, c);
        wr(O_PRE, 32'd2, c);
        wr(O_CTRL, 32'd3, c);
        bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1; bus.ADR = BASE; bus.DAT_O = 32'h1234;
        @(negedge clk);
        vectors++;
        if (bus.ACK !== 1'b1) begin miscompares++; $display("FAIL mid_ack_before: got %b, required 1", bus.ACK); end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.ACK !== 1'b0 || bus.DAT_I !== 32'd0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: ack=%b dat=%h irq=%b, required 0 0 0", bus.ACK, bus.DAT_I, irq);
        end
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_start = '0; m_cmp = '1; m_en_edge = NEVER; m_p = 0; m_ie = 1'b0; m_snap = '0;
        check_reset_regs("mid_reset_regs");
    endtask

    task automatic test_random_timer();
        logic [31:0] d;
        logic [63:0] start;
        logic [63:0] e;
        int c;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            case ($urandom % 3)
                0:       start = {32'd0, 32'($urandom_range(0, 1000))};
                1:       start = {32'($urandom), 32'hFFFF_FFF0 | 32'($urandom % 16)};
                default: start = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
            endcase
            setup_timer($urandom_range(0, 4), start, start + 64'($urandom_range(0, 40)),
                        1'($urandom % 2));
            repeat ($urandom_range(20, 60)) begin
                @(negedge clk);
                vectors++;
                if (irq !== exp_irq(cyc)) begin
                    miscompares++;
                    $display("FAIL rnd_irq it=%0d cyc=%0d: got %b, required %b", it, cyc, irq, exp_irq(cyc));
                end
            end
            rd(O_LO, d, c);
            e = mt_at(c - 1);
            vectors++;
            if (d !== e[31:0]) begin miscompares++; $display("FAIL rnd_lo it=%0d: got %h, required %h", it, d, e[31:0]); end
            rd(O_HI, d, c);
            vectors++;
            if (d !== exp_hi(c)) begin miscompares++; $display("FAIL rnd_hi it=%0d: got %h, required %h", it, d, exp_hi(c)); end
            wr(O_CTRL, 32'd0, c);
            m_start = mt_at(c);
            m_en_edge = NEVER;
            repeat (5) @(negedge clk);
            rd(O_LO, d, c);
            vectors++;
            if (d !== m_start[31:0]) begin
                miscompares++; $display("FAIL rnd_frozen it=%0d: got %h, required %h", it, d, m_start[31:0]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.ADR = '0; bus.DAT_O = '0;
        m_start = '0; m_cmp = '1; m_en_edge = NEVER; m_p = 0; m_ie = 1'b0; m_snap = '0;
        @(negedge clk);
        test_reset();
        test_regs();
        test_prescale();
        test_carry();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        test_random_timer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_4000, meaning the 32-byte aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE_W, default 16, meaning the width of the prescaler register and counter.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port CYC  input  1  bus cycle valid.
REQ-006 SHALL have port STB  input  1  strobe.
REQ-007 SHALL have port WE  input  1  write enable.
REQ-008 SHALL have port ADR  input  32  byte address.
REQ-009 SHALL have port DAT_O  input  32  write data, driven by the master.
REQ-010 SHALL have port DAT_I  output  32  read data, driven by this block.
REQ-011 SHALL have port ACK  output  1  transfer acknowledge.
REQ-012 SHALL have port irq  output  1  level timer interrupt.

Function
REQ-013 SHALL select the block when ADR[31:5]==BASE_ADDR[31:5]; ADR[4:2] SHALL pick the register; ADR[1:0] SHALL be ignored.
REQ-014 SHALL map the registers as: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI, 0x10 CTRL (bit0 EN, bit1 IE, rest read 0), 0x14 PRESCALE (low PRESCALE_W bits, rest read 0).
REQ-015 SHALL read offsets 0x18 and 0x1C as 0, ignore writes to them, and still ACK them.
REQ-016 SHALL run a two-state FSM, IDLE and RESP: IDLE->RESP on the edge where CYC&STB&selected; RESP->IDLE unconditionally on the next edge.
REQ-017 SHALL hold ACK high exactly while in RESP (one-cycle pulse, one cycle latency), and SHALL never ACK unselected addresses.
REQ-018 SHALL ACK a held CYC&STB again only after one IDLE cycle, i.e. at most one ACK every 2 cycles.
REQ-019 SHALL commit writes on the IDLE->RESP edge and register read data into DAT_I on the same edge; DAT_I is valid only while ACK=1 and holds its last value otherwise.
REQ-020 SHALL, with EN=1, count the prescaler 0..PRESCALE, incrementing the 64-bit mtime and clearing the prescaler on the cycle the count equals PRESCALE; PRESCALE=0 SHALL give one tick per clock.
REQ-021 SHALL freeze mtime and the prescaler while EN=0, with values kept.
REQ-022 SHALL let mtime wrap from 2^64-1 to 0 with no flag.
REQ-023 SHALL, when a bus write to MTIME_LO/HI lands on a tick cycle, load the written word and SHALL NOT apply that tick's increment to either half.
REQ-024 SHALL clear the prescaler on any write to PRESCALE.
REQ-025 SHALL set irq as a register of (IE & (mtime >= {CMP_HI,CMP_LO})), using an unsigned 64-bit compare, so irq lags the compare by one cycle.
REQ-026 SHALL provide no irq acknowledge; software clears irq by raising CMP or clearing IE.

Reset
REQ-027 SHALL, while rst=0, force immediately: ACK=0, FSM=IDLE, DAT_I=0, irq=0, mtime=0, prescaler=0, CMP=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0.
REQ-028 SHALL abandon a transfer in flight when reset asserts (no ACK issued); the master re-issues it after rst=1.

Configuration
REQ-029 SHALL implement macro TIMER_SNAPSHOT_EN: when defined, a read of MTIME_LO SHALL capture mtime[63:32] into a shadow register and reads of MTIME_HI SHALL return the shadow (reset 0); when undefined, there SHALL be no shadow and MTIME_HI reads SHALL return live mtime[63:32].

Verification
REQ-030 SHALL cover reset then read CMP_HI -> ACK 1 cycle after STB, DAT_I=32'hFFFF_FFFF, irq=0.
REQ-031 SHALL cover PRESCALE=3, EN=1, 40 cycles -> MTIME_LO reads 10 (±1 for bus timing), computed by the checker per REQ-020.
REQ-032 SHALL cover mtime=32'hFFFF_FFFF in LO, PRESCALE=0, EN=1 -> the next tick gives LO=0, HI=1; with TIMER_SNAPSHOT_EN, an LO read before the carry then an HI read returns 0.
REQ-033 SHALL cover CMP=100, IE=1, EN=1, PRESCALE=0 from mtime=0 -> irq rises the cycle after mtime reaches 100; writing CMP_LO=1000 drops irq 1 cycle after commit.
REQ-034 SHALL cover CYC&STB held 6 cycles on one selected address -> exactly 3 ACK pulses; an access at BASE_ADDR+0x20 -> no ACK ever.
REQ-035 SHALL cover rst pulsed low during RESP after a write to MTIME_LO -> ACK drops immediately and all registers read reset values.
